// File: rtl/apb_cmd_master.sv
// ============================================================================
//  Module   : apb_cmd_master
//  Brief    : Valid/ready command stream to APB3 master, one transfer in flight
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module apb_cmd_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // command stream
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // response stream
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  timeout,
    // APB3 master
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_SETUP  = 2'd1;
    localparam logic [1:0] C_ACCESS = 2'd2;
    localparam logic [1:0] C_RESP   = 2'd3;

    // Counter kept at least one bit wide so TIMEOUT=0 still elaborates.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_expired;

    assign cmd_ready = (r_state == C_IDLE);
    assign w_expired = (TIMEOUT != 0) && (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= C_IDLE;
            r_cnt     <= '0;
            paddr     <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (r_state)
                C_IDLE: begin
                    if (cmd_valid) begin
                        paddr   <= cmd_addr;
                        pwrite  <= cmd_write;
                        pwdata  <= cmd_wdata;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        r_state <= C_SETUP;
                    end
                end
                C_SETUP: begin
                    penable <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= C_ACCESS;
                end
                C_ACCESS: begin
                    // pready takes priority over an expiring timeout in the same cycle
                    if (pready) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pwrite ? '0 : prdata;
                        rsp_err   <= pslverr;
                        r_state   <= C_RESP;
                    end else if (w_expired) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        timeout   <= 1'b1;
                        r_state   <= C_RESP;
                    end else if (r_cnt != C_CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                C_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= C_IDLE;
                    end
                end
                default: r_state <= C_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
// ============================================================================
//  Module   : tb_apb_cmd_master
//  Brief    : Directed self-checking bench for apb_cmd_master with APB slave model
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_apb_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, timeout;
    logic [31:0] rsp_rdata;
    logic [7:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;

    // slave model controls
    int          stall;
    logic        err_inject, err_early;
    int          acc_cnt;
    logic [31:0] mem [256];

    int total = 0;
    int bad   = 0;

    // per-command observations
    int          lat, n_setup, n_acc, n_to;
    logic [31:0] got_rd;
    logic        got_er, stable, accepted, ready_after, psel_at_rsp;

    always #5 clk = ~clk;

    apb_cmd_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .timeout(timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    assign pready  = psel && penable && (acc_cnt >= stall);
    assign pslverr = (err_inject && pready) || (err_early && !pready);
    assign prdata  = mem[paddr];

    always @(posedge clk) begin
        acc_cnt <= (psel && penable) ? acc_cnt + 1 : 0;
        if (psel && penable && pready && pwrite && !pslverr)
            mem[paddr] <= pwdata;
    end

    // Issue one command from IDLE and observe it until one cycle after its response.
    task automatic run_cmd(input logic wr, input logic [7:0] a, input logic [31:0] wd);
        lat = 0; n_setup = 0; n_acc = 0; n_to = 0; stable = 1'b1;
        got_rd = '0; got_er = 1'b0; psel_at_rsp = 1'b1;
        cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_valid = 1'b1;
        accepted = cmd_ready;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (timeout) n_to++;
            if (psel && !penable) n_setup++;
            if (psel && penable) n_acc++;
            if (psel && (paddr !== a || pwrite !== wr || (wr && pwdata !== wd))) stable = 1'b0;
            if (rsp_valid) begin
                lat = i; got_rd = rsp_rdata; got_er = rsp_err; psel_at_rsp = psel;
                break;
            end
        end
        @(negedge clk);
        if (timeout) n_to++;
        ready_after = cmd_ready;
    endtask

    task automatic test_reset;
        total++; if ({psel, penable, pwrite} !== 3'b000) begin bad++; $display("FAIL reset_apb_ctrl: got %b want 000", {psel, penable, pwrite}); end
        total++; if ({paddr, pwdata} !== 40'h0) begin bad++; $display("FAIL reset_apb_data: got %h want 0", {paddr, pwdata}); end
        total++; if ({rsp_valid, rsp_err, timeout, rsp_rdata} !== 35'h0) begin bad++; $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_err, timeout, rsp_rdata}); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_write_read;
        stall = 0;
        run_cmd(1'b1, 8'h04, 32'hDEADBEEF);
        total++; if (accepted !== 1'b1) begin bad++; $display("FAIL wr_accept: got %b want 1", accepted); end
        total++; if (lat !== 3) begin bad++; $display("FAIL wr_latency: got %0d want 3", lat); end
        total++; if (n_setup !== 1 || n_acc !== 1) begin bad++; $display("FAIL wr_phases: got setup=%0d access=%0d want 1/1", n_setup, n_acc); end
        total++; if (got_rd !== 32'h0 || got_er !== 1'b0) begin bad++; $display("FAIL wr_rsp: got rdata=%h err=%b want 0/0", got_rd, got_er); end
        total++; if (ready_after !== 1'b1) begin bad++; $display("FAIL wr_ready_n4: got %b want 1", ready_after); end
        run_cmd(1'b0, 8'h04, 32'h0);
        total++; if (lat !== 3) begin bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
        total++; if (got_rd !== 32'hDEADBEEF || got_er !== 1'b0) begin bad++; $display("FAIL rd_rsp: got rdata=%h err=%b want deadbeef/0", got_rd, got_er); end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL rd_stable: got %b want 1", stable); end
    endtask

    task automatic test_wait_states;
        stall = 0;
        run_cmd(1'b1, 8'h08, 32'h12345678);
        stall = 3;
        run_cmd(1'b0, 8'h08, 32'h0);
        total++; if (n_acc !== 4) begin bad++; $display("FAIL ws_access_cycles: got %0d want 4", n_acc); end
        total++; if (lat !== 6) begin bad++; $display("FAIL ws_latency: got %0d want 6", lat); end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL ws_addr_stable: got %b want 1", stable); end
        total++; if (got_rd !== 32'h12345678 || got_er !== 1'b0) begin bad++; $display("FAIL ws_rsp: got rdata=%h err=%b want 12345678/0", got_rd, got_er); end
    endtask

    task automatic test_slverr;
        stall = 0; err_inject = 1'b1;
        run_cmd(1'b1, 8'h0C, 32'hCAFEF00D);
        err_inject = 1'b0;
        total++; if (got_er !== 1'b1 || n_to !== 0) begin bad++; $display("FAIL slverr_rsp: got err=%b timeouts=%0d want 1/0", got_er, n_to); end
        total++; if (got_rd !== 32'h0) begin bad++; $display("FAIL slverr_rdata: got %h want 0", got_rd); end
        // error asserted only while pready is low must not leak through
        stall = 2; err_early = 1'b1;
        run_cmd(1'b1, 8'h0C, 32'h1);
        err_early = 1'b0;
        total++; if (got_er !== 1'b0 || n_acc !== 3) begin bad++; $display("FAIL early_err_ignored: got err=%b access=%0d want 0/3", got_er, n_acc); end
    endtask

    task automatic test_timeout;
        stall = 1000;
        run_cmd(1'b0, 8'h04, 32'h0);
        total++; if (n_acc !== 16) begin bad++; $display("FAIL to_access_cycles: got %0d want 16", n_acc); end
        total++; if (lat !== 18) begin bad++; $display("FAIL to_latency: got %0d want 18", lat); end
        total++; if (n_to !== 1) begin bad++; $display("FAIL to_pulse_count: got %0d want 1", n_to); end
        total++; if (got_er !== 1'b1 || got_rd !== 32'h0) begin bad++; $display("FAIL to_rsp: got err=%b rdata=%h want 1/0", got_er, got_rd); end
        total++; if (psel_at_rsp !== 1'b0) begin bad++; $display("FAIL to_psel_drop: got %b want 0", psel_at_rsp); end
        stall = 0;
        run_cmd(1'b1, 8'h10, 32'hA5A50F0F);
        stall = 15;
        run_cmd(1'b0, 8'h10, 32'h0);
        total++; if (n_acc !== 16 || n_to !== 0) begin bad++; $display("FAIL race_no_timeout: got access=%0d timeouts=%0d want 16/0", n_acc, n_to); end
        total++; if (got_er !== 1'b0 || got_rd !== 32'hA5A50F0F) begin bad++; $display("FAIL race_rsp: got err=%b rdata=%h want 0/a5a50f0f", got_er, got_rd); end
        stall = 0;
    endtask

    task automatic test_back_to_back;
        stall = 0;
        run_cmd(1'b1, 8'h18, 32'h00000011);
        run_cmd(1'b0, 8'h18, 32'h0);
        total++; if (accepted !== 1'b1 || lat !== 3 || got_rd !== 32'h00000011) begin bad++; $display("FAIL b2b_second: got acc=%b lat=%0d rdata=%h want 1/3/00000011", accepted, lat, got_rd); end
    endtask

    task automatic test_backpressure;
        logic        hold_ok;
        logic        seen;
        stall = 0; rsp_ready = 1'b0; seen = 1'b0; hold_ok = 1'b1;
        cmd_write = 1'b0; cmd_addr = 8'h04; cmd_wdata = '0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL bp_rsp_seen: got %b want 1", seen); end
        cmd_write = 1'b1; cmd_addr = 8'h14; cmd_wdata = 32'h0BADF00D; cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || cmd_ready !== 1'b0 || psel !== 1'b0) hold_ok = 1'b0;
        end
        total++; if (hold_ok !== 1'b1) begin bad++; $display("FAIL bp_hold: got %b want 1", hold_ok); end
        rsp_ready = 1'b1;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || psel !== 1'b0) begin bad++; $display("FAIL bp_after_hs: got valid=%b ready=%b psel=%b want 0/1/0", rsp_valid, cmd_ready, psel); end
        @(negedge clk);
        cmd_valid = 1'b0;
        total++; if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 8'h14) begin bad++; $display("FAIL bp_accept: got psel=%b penable=%b paddr=%h want 1/0/14", psel, penable, paddr); end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        total++; if (seen !== 1'b1 || rsp_err !== 1'b0) begin bad++; $display("FAIL bp_second_rsp: got valid=%b err=%b want 1/0", seen, rsp_err); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic stray;
        stall = 1000; stray = 1'b0;
        cmd_write = 1'b0; cmd_addr = 8'h20; cmd_wdata = '0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++; if (psel !== 1'b1 || penable !== 1'b1) begin bad++; $display("FAIL rm_in_access: got psel=%b penable=%b want 1/1", psel, penable); end
        rst_n = 1'b0;
        #1;
        total++; if ({psel, penable, rsp_valid} !== 3'b000) begin bad++; $display("FAIL rm_immediate: got %b want 000", {psel, penable, rsp_valid}); end
        @(negedge clk);
        rst_n = 1'b1;
        stall = 0;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rm_cmd_ready: got %b want 1", cmd_ready); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid || psel || timeout) stray = 1'b1;
        end
        total++; if (stray !== 1'b0) begin bad++; $display("FAIL rm_no_stray: got %b want 0", stray); end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1; stall = 0; err_inject = 1'b0; err_early = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_write_read;
        test_wait_states;
        test_slverr;
        test_timeout;
        test_back_to_back;
        test_backpressure;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
